// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
// Optional build macro used by this slice: CLK_DIV_MON_SYNC_EN.
package clk_div_mon_pkg;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } mon_state_t;

   localparam int CNT_W_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;

   // match_cnt is 4 bits wide, so LOCK_CNT-1 must fit in 0..14
   function automatic bit lock_cnt_ok(input int n);
      return (n >= 2) && (n <= 15);
   endfunction

endpackage

// File: rtl/div_edge_detect.sv
// Samples div_in and produces an aligned level / rising-edge pair.
// CLK_DIV_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sampling register.
module div_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic div_in,
   output logic lvl,
   output logic rise
);

   logic samp_in;
   logic s_p1;
   logic s_d_p2;
   logic rise_p2;

`ifdef CLK_DIV_MON_SYNC_EN
   logic meta_p0;
   logic sync_p0;

   // synchronizer stage
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p0 <= 1'b0;
         sync_p0 <= 1'b0;
      end else begin
         meta_p0 <= div_in;
         sync_p0 <= meta_p0;
      end
   end

   assign samp_in = sync_p0;
`else
   assign samp_in = div_in;
`endif

   // sample stage; rise is registered so it lines up with s_d as the level
   always_ff @(posedge clk) begin
      if (rst) begin
         s_p1    <= 1'b0;
         s_d_p2  <= 1'b0;
         rise_p2 <= 1'b0;
      end else begin
         s_p1    <= samp_in;
         s_d_p2  <= s_p1;
         rise_p2 <= s_p1 & ~s_d_p2;
      end
   end

   assign lvl  = s_d_p2;
   assign rise = rise_p2;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a divided clock in clk cycles and flags lock.
// Build macro CLK_DIV_MON_SYNC_EN enables the input synchronizer (2 extra cycles latency).
module clk_div_monitor
   import clk_div_mon_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W:0]   period,
   output logic             meas_valid,
   output logic             locked,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] ACC_MAX   = '1;
   localparam logic [3:0]       MATCH_TOP = 4'(LOCK_CNT - 1);

   if (!lock_cnt_ok(LOCK_CNT)) begin : g_lock_cnt_range
      $error("clk_div_monitor: LOCK_CNT must be in 2..15");
   end

   function automatic logic [3:0] match_sat_inc(input logic [3:0] m);
      return (m >= MATCH_TOP) ? MATCH_TOP : m + 4'd1;
   endfunction

   logic             lvl_p2;
   logic             rise_p2;
   mon_state_t       state;
   mon_state_t       state_nxt;
   logic [CNT_W-1:0] hi_acc;
   logic [CNT_W-1:0] lo_acc;
   logic [3:0]       match_cnt;
   logic             publish;
   logic             first_pub;
   logic             acc_inc;
   logic             sat;
   logic             same_pair;

   div_edge_detect u_edge (
      .clk    (clk),
      .rst    (rst),
      .div_in (div_in),
      .lvl    (lvl_p2),
      .rise   (rise_p2)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= SEEK;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEEK:    if (rise_p2) state_nxt = ACQ;
         ACQ: begin
            if (rise_p2)  state_nxt = TRACK;
            else if (sat) state_nxt = SEEK;
         end
         TRACK:   if (sat) state_nxt = SEEK;
         default: state_nxt = SEEK;
      endcase
   end

   // Edge cycles load the accumulators, so saturation can only arise on a non-edge cycle
   always_comb begin
      publish   = 1'b0;
      first_pub = 1'b0;
      acc_inc   = 1'b0;
      sat       = 1'b0;
      case (state)
         ACQ, TRACK: begin
            if (rise_p2) begin
               publish   = 1'b1;
               first_pub = (state == ACQ);
            end else begin
               acc_inc = 1'b1;
               sat     = lvl_p2 ? (hi_acc == ACC_MAX) : (lo_acc == ACC_MAX);
            end
         end
         default: ;
      endcase
   end

   assign same_pair = (hi_acc == high_cnt) && (lo_acc == low_cnt);

   // accumulate / publish stage
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_acc     <= '0;
         lo_acc     <= '0;
         high_cnt   <= '0;
         low_cnt    <= '0;
         period     <= '0;
         meas_valid <= 1'b0;
         match_cnt  <= 4'd0;
         ovf        <= 1'b0;
      end else begin
         meas_valid <= publish;
         if (rise_p2) begin
            hi_acc <= {{(CNT_W-1){1'b0}}, 1'b1};
            lo_acc <= '0;
         end else if (acc_inc && !sat) begin
            if (lvl_p2) hi_acc <= hi_acc + 1'b1;
            else        lo_acc <= lo_acc + 1'b1;
         end
         if (publish) begin
            high_cnt <= hi_acc;
            low_cnt  <= lo_acc;
            period   <= {1'b0, hi_acc} + {1'b0, lo_acc};
            if (first_pub || !same_pair) match_cnt <= 4'd0;
            else                         match_cnt <= match_sat_inc(match_cnt);
         end
         if (sat) begin
            ovf       <= 1'b1;
            match_cnt <= 4'd0;
         end
      end
   end

   assign locked = (match_cnt == MATCH_TOP);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor against a window-counting reference model.
module tb_clk_div_monitor;
   import clk_div_mon_pkg::*;

`ifdef CLK_DIV_MON_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int LOCK = 4;
   localparam int MAX  = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       div_in = 1'b0;
   logic [7:0] high_cnt, low_cnt;
   logic [8:0] period;
   logic       meas_valid, locked, ovf;

   logic       div4 = 1'b0;
   logic [3:0] high_cnt4, low_cnt4;
   logic [4:0] period4;
   logic       meas_valid4, locked4, ovf4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_div_monitor #(.CNT_W(8), .LOCK_CNT(LOCK)) dut (
      .clk(clk), .rst(rst), .div_in(div_in),
      .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
      .meas_valid(meas_valid), .locked(locked), .ovf(ovf)
   );

   clk_div_monitor #(.CNT_W(4), .LOCK_CNT(LOCK)) dut4 (
      .clk(clk), .rst(rst), .div_in(div4),
      .high_cnt(high_cnt4), .low_cnt(low_cnt4), .period(period4),
      .meas_valid(meas_valid4), .locked(locked4), .ovf(ovf4)
   );

   typedef struct {
      logic       mv;
      logic [7:0] hi;
      logic [7:0] lo;
      logic [8:0] per;
      logic       lk;
      logic       ov;
   } snap_t;

   // Reference model: the sampled waveform history, the index where the current
   // period began, and the run length of identical published measurements.
   bit    hist[$];
   snap_t snaps[$];
   snap_t cur;
   snap_t zero_snap;
   bit    m_started, m_first;
   int    m_st, m_run, pv_hi, pv_lo;
   bit    seq[$];

   task automatic model_reset();
      hist.delete();
      snaps.delete();
      m_started = 0; m_first = 0; m_st = 0; m_run = 0; pv_hi = -1; pv_lo = -1;
      cur = '{default: 0};
      zero_snap = '{default: 0};
   endtask

   task automatic model_sample(input bit v);
      int n, h, l;
      bit prev, rise;
      prev = (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
      hist.push_back(v);
      n = hist.size() - 1;
      rise = v & ~prev;
      cur.mv = 0;
      if (m_started && rise) begin
         h = 0;
         for (int i = m_st; i < n; i++) h += int'(hist[i]);
         l = (n - m_st) - h;
         cur.mv = 1; cur.hi = 8'(h); cur.lo = 8'(l); cur.per = 9'(n - m_st);
         if (m_first) m_run = 1;
         else if (h == pv_hi && l == pv_lo) m_run = m_run + 1;
         else m_run = 1;
         m_first = 0; pv_hi = h; pv_lo = l; m_st = n;
      end else if (m_started) begin
         h = 0;
         for (int i = m_st; i <= n; i++) h += int'(hist[i]);
         l = (n - m_st + 1) - h;
         if (h > MAX || l > MAX) begin
            m_started = 0; m_run = 0; cur.ov = 1;
         end
      end else if (rise) begin
         m_started = 1; m_first = 1; m_st = n;
      end
      cur.lk = (m_run >= LOCK);
      snaps.push_back(cur);
   endtask

   task automatic step(input bit v, output snap_t e);
      div_in = v;
      @(posedge clk);
      model_sample(v);
      #1;
      if (snaps.size() > LAT) e = snaps[snaps.size()-1-LAT];
      else e = zero_snap;
   endtask

   task automatic add_period(input int h, input int l);
      repeat (h) seq.push_back(1'b1);
      repeat (l) seq.push_back(1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         div_in = 1'($urandom_range(0, 1));
         @(posedge clk);
      end
      #1;
      checks += 6;
      if (high_cnt !== 8'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_cnt); end
      if (low_cnt !== 8'd0) begin errors++; $display("FAIL reset_low got %0d exp 0", low_cnt); end
      if (period !== 9'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
      if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", meas_valid); end
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      div_in = 1'b0;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_basic_35();
      snap_t e;
      int k = 0;
      seq.delete();
      seq.push_back(1'b0); seq.push_back(1'b0);
      repeat (6) add_period(3, 5);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 3;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL b35_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL b35_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (ovf !== e.ov) begin errors++; $display("FAIL b35_ovf i=%0d got %b exp %b", i, ovf, e.ov); end
         if (meas_valid === 1'b1) begin
            k++;
            checks += 4;
            if (high_cnt !== 8'd3) begin errors++; $display("FAIL b35_high pub=%0d got %0d exp 3", k, high_cnt); end
            if (low_cnt !== 8'd5) begin errors++; $display("FAIL b35_low pub=%0d got %0d exp 5", k, low_cnt); end
            if (period !== 9'd8) begin errors++; $display("FAIL b35_period pub=%0d got %0d exp 8", k, period); end
            if (locked !== (k >= 4)) begin errors++; $display("FAIL b35_lock_pub pub=%0d got %b exp %b", k, locked, (k >= 4)); end
            if (k == 1) begin
               checks++;
               if (i != 10 + LAT) begin errors++; $display("FAIL b35_first_latency got idx %0d exp %0d", i, 10 + LAT); end
            end
         end
      end
      checks++;
      if (k != 5) begin errors++; $display("FAIL b35_pub_count got %0d exp 5", k); end
   endtask

   task automatic test_relock();
      snap_t e;
      int k = 0;
      seq.delete();
      add_period(4, 5);
      repeat (5) add_period(3, 5);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 3;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL relock_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL relock_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (ovf !== e.ov) begin errors++; $display("FAIL relock_ovf i=%0d got %b exp %b", i, ovf, e.ov); end
         if (meas_valid === 1'b1) begin
            k++;
            checks += 3;
            if (high_cnt !== ((k == 2) ? 8'd4 : 8'd3)) begin errors++; $display("FAIL relock_high pub=%0d got %0d", k, high_cnt); end
            if (period !== ((k == 2) ? 9'd9 : 9'd8)) begin errors++; $display("FAIL relock_period pub=%0d got %0d", k, period); end
            if (locked !== (k == 1 || k >= 6)) begin errors++; $display("FAIL relock_lock_pub pub=%0d got %b exp %b", k, locked, (k == 1 || k >= 6)); end
         end
      end
      checks++;
      if (k != 6) begin errors++; $display("FAIL relock_pub_count got %0d exp 6", k); end
   endtask

   task automatic test_min_period();
      snap_t e;
      int k = 0;
      int last = 0;
      seq.delete();
      repeat (12) add_period(1, 1);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 3;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL min_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL min_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (ovf !== e.ov) begin errors++; $display("FAIL min_ovf i=%0d got %b exp %b", i, ovf, e.ov); end
         if (meas_valid === 1'b1) begin
            k++;
            if (k >= 2) begin
               checks += 3;
               if (high_cnt !== 8'd1) begin errors++; $display("FAIL min_high pub=%0d got %0d exp 1", k, high_cnt); end
               if (low_cnt !== 8'd1) begin errors++; $display("FAIL min_low pub=%0d got %0d exp 1", k, low_cnt); end
               if (period !== 9'd2) begin errors++; $display("FAIL min_period pub=%0d got %0d exp 2", k, period); end
            end
            if (k >= 3) begin
               checks++;
               if (i - last != 2) begin errors++; $display("FAIL min_spacing pub=%0d got %0d exp 2", k, i - last); end
            end
            last = i;
         end
      end
      checks++;
      if (k < 8) begin errors++; $display("FAIL min_pub_count got %0d exp >=8", k); end
   endtask

   task automatic test_random();
      snap_t e;
      int h, l, r;
      seq.delete();
      repeat (40) begin
         h = $urandom_range(1, 12);
         l = $urandom_range(1, 12);
         r = $urandom_range(1, 6);
         repeat (r) add_period(h, l);
      end
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 3;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL rand_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL rand_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (ovf !== e.ov) begin errors++; $display("FAIL rand_ovf i=%0d got %b exp %b", i, ovf, e.ov); end
         if (e.mv) begin
            checks += 3;
            if (high_cnt !== e.hi) begin errors++; $display("FAIL rand_high i=%0d got %0d exp %0d", i, high_cnt, e.hi); end
            if (low_cnt !== e.lo) begin errors++; $display("FAIL rand_low i=%0d got %0d exp %0d", i, low_cnt, e.lo); end
            if (period !== e.per) begin errors++; $display("FAIL rand_period i=%0d got %0d exp %0d", i, period, e.per); end
         end
      end
   endtask

   task automatic test_ovf_long();
      snap_t e;
      seq.delete();
      add_period(2, 300);
      repeat (3) add_period(3, 5);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 3;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL ovfl_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL ovfl_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (ovf !== e.ov) begin errors++; $display("FAIL ovfl_ovf i=%0d got %b exp %b", i, ovf, e.ov); end
         if (e.mv) begin
            checks += 2;
            if (high_cnt !== e.hi) begin errors++; $display("FAIL ovfl_high i=%0d got %0d exp %0d", i, high_cnt, e.hi); end
            if (low_cnt !== e.lo) begin errors++; $display("FAIL ovfl_low i=%0d got %0d exp %0d", i, low_cnt, e.lo); end
         end
      end
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL ovfl_sticky got %b exp 1", ovf); end
   endtask

   task automatic test_mid_reset();
      snap_t e;
      int first = -1;
      seq.delete();
      repeat (6) add_period(3, 5);
      seq.push_back(1'b1); seq.push_back(1'b1);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 2;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL mrst_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL mrst_locked i=%0d got %b exp %b", i, locked, e.lk); end
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL mrst_pre_locked got %b exp 1", locked); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks += 6;
      if (high_cnt !== 8'd0) begin errors++; $display("FAIL mrst_high got %0d exp 0", high_cnt); end
      if (low_cnt !== 8'd0) begin errors++; $display("FAIL mrst_low got %0d exp 0", low_cnt); end
      if (period !== 9'd0) begin errors++; $display("FAIL mrst_period got %0d exp 0", period); end
      if (meas_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid0 got %b exp 0", meas_valid); end
      if (locked !== 1'b0) begin errors++; $display("FAIL mrst_locked0 got %b exp 0", locked); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL mrst_ovf0 got %b exp 0", ovf); end
      rst = 1'b0;
      div_in = 1'b0;
      model_reset();
      seq.delete();
      repeat (3) add_period(3, 5);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], e);
         checks += 2;
         if (meas_valid !== e.mv) begin errors++; $display("FAIL mrst_post_valid i=%0d got %b exp %b", i, meas_valid, e.mv); end
         if (locked !== e.lk) begin errors++; $display("FAIL mrst_post_locked i=%0d got %b exp %b", i, locked, e.lk); end
         if (meas_valid === 1'b1 && first < 0) first = i;
      end
      checks++;
      if (first != 8 + LAT) begin errors++; $display("FAIL mrst_first_latency got idx %0d exp %0d", first, 8 + LAT); end
   endtask

   task automatic test_ovf_w4();
      int pubs = 0;
      rst = 1'b1;
      div_in = 1'b0;
      div4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int j = 0; j < 30; j++) begin
         div4 = (j == 2);
         @(posedge clk);
         #1;
         checks += 3;
         if (ovf4 !== (j >= 18 + LAT)) begin errors++; $display("FAIL w4_ovf j=%0d got %b exp %b", j, ovf4, (j >= 18 + LAT)); end
         if (meas_valid4 !== 1'b0) begin errors++; $display("FAIL w4_valid j=%0d got %b exp 0", j, meas_valid4); end
         if (locked4 !== 1'b0) begin errors++; $display("FAIL w4_locked j=%0d got %b exp 0", j, locked4); end
      end
      checks++;
      if (dut4.state !== SEEK) begin errors++; $display("FAIL w4_state got %0d exp %0d", dut4.state, SEEK); end
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 8; j++) begin
            div4 = (j < 3);
            @(posedge clk);
            #1;
            checks++;
            if (ovf4 !== 1'b1) begin errors++; $display("FAIL w4_sticky p=%0d j=%0d got %b exp 1", p, j, ovf4); end
            if (meas_valid4 === 1'b1) begin
               pubs++;
               checks += 2;
               if (high_cnt4 !== 4'd3) begin errors++; $display("FAIL w4_high got %0d exp 3", high_cnt4); end
               if (period4 !== 5'd8) begin errors++; $display("FAIL w4_period got %0d exp 8", period4); end
            end
         end
      end
      checks++;
      if (pubs != 3) begin errors++; $display("FAIL w4_pub_count got %0d exp 3", pubs); end
      div4 = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks += 2;
      if (ovf4 !== 1'b0) begin errors++; $display("FAIL w4_ovf_clear got %b exp 0", ovf4); end
      if (meas_valid4 !== 1'b0) begin errors++; $display("FAIL w4_valid_clear got %b exp 0", meas_valid4); end
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_35();
      test_relock();
      test_min_period();
      test_random();
      test_ovf_long();
      test_mid_reset();
      test_ovf_w4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
